// File: rtl/kamikaze_pkg.sv
// kamikaze_pkg: opcode class codes, immediate formats and the decoded-record type
// shared by the instruction decoder and its immediate generator.
package kamikaze_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  // Register indices are kept at full 5-bit width; the top truncates to RW on output.
  typedef struct packed {
    logic [4:0] opc;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_en;
    logic       rs2_en;
    logic       rd_we;
    logic       illegal;
  } dec_t;

  function automatic logic reg_oob(input logic [4:0] idx, input int nregs);
    return (32'(idx) >= 32'(nregs));
  endfunction

endpackage

// File: rtl/kamikaze_immgen.sv
// kamikaze_immgen: combinational RISC-V immediate extraction, sign-extended to XLEN.
module kamikaze_immgen
  import kamikaze_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:7]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] w_imm32;

  // Assemble the 32-bit immediate; bit 31 of the instruction is always the sign.
  always_comb begin
    w_imm32 = 32'd0;
    case (fmt_i)
      IMM_I:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
      IMM_U:   w_imm32 = {instr_i[31:12], 12'd0};
      IMM_J:   w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
  end

  assign imm_o = XLEN'($signed(w_imm32));

endmodule

// File: rtl/kamikaze_idecode.sv
// kamikaze_idecode: single-stage RV32I/RV32E decoder with valid/ready handshakes.
// Define KAMIKAZE_DEC_SKID_EN to add a one-entry skid buffer and a registered ready_o.
module kamikaze_idecode
  import kamikaze_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEFAULT,
  parameter int  NREGS = 32,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      opc_o,
  output logic [2:0]      funct3_o,
  output logic            funct7b5_o,
  output logic [RW-1:0]   rs1_o,
  output logic [RW-1:0]   rs2_o,
  output logic [RW-1:0]   rd_o,
  output logic            rs1_en_o,
  output logic            rs2_en_o,
  output logic            rd_we_o,
  output logic            illegal_o
);

  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_known;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_use_rd;
  logic            w_illegal;
  logic            w_rd_we;
  logic            w_load;
  imm_fmt_e        w_fmt_cls;
  imm_fmt_e        w_fmt;
  dec_t            w_dec;
  logic [XLEN-1:0] w_imm;

  logic            r_valid;
  dec_t            r_out;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;

  assign w_rs1 = instr_i[19:15];
  assign w_rs2 = instr_i[24:20];
  assign w_rd  = instr_i[11:7];

  // Classify the opcode and record which register fields it references.
  always_comb begin
    w_known   = 1'b1;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_fmt_cls = IMM_NONE;
    case (instr_i[6:2])
      OPC_OP_IMM: begin w_fmt_cls = IMM_I;    w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      OPC_LUI:    begin w_fmt_cls = IMM_U;    w_use_rd  = 1'b1; end
      OPC_AUIPC:  begin w_fmt_cls = IMM_U;    w_use_rd  = 1'b1; end
      OPC_OP:     begin w_fmt_cls = IMM_NONE; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; end
      OPC_JAL:    begin w_fmt_cls = IMM_J;    w_use_rd  = 1'b1; end
      OPC_JALR:   begin w_fmt_cls = IMM_I;    w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      OPC_BRANCH: begin w_fmt_cls = IMM_B;    w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_LOAD:   begin w_fmt_cls = IMM_I;    w_use_rs1 = 1'b1; w_use_rd = 1'b1; end
      OPC_STORE:  begin w_fmt_cls = IMM_S;    w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_SYSTEM: begin w_fmt_cls = IMM_I;    w_use_rd  = 1'b1; end
      default:    begin w_known   = 1'b0; end
    endcase
  end

  assign w_illegal = (instr_i[1:0] != 2'b11) || !w_known
                   || (w_use_rs1 && reg_oob(w_rs1, NREGS))
                   || (w_use_rs2 && reg_oob(w_rs2, NREGS))
                   || (w_use_rd  && reg_oob(w_rd,  NREGS));
  assign w_fmt     = w_illegal ? IMM_NONE : w_fmt_cls;
  assign w_rd_we   = !w_illegal && w_use_rd && (w_rd != 5'd0);

  // Build the decoded record; disabled register fields are forced to zero.
  always_comb begin
    w_dec          = '0;
    w_dec.opc      = instr_i[6:2];
    w_dec.funct3   = instr_i[14:12];
    w_dec.funct7b5 = instr_i[30];
    w_dec.illegal  = w_illegal;
    if (!w_illegal) begin
      w_dec.rs1_en = w_use_rs1;
      w_dec.rs2_en = w_use_rs2;
      w_dec.rd_we  = w_rd_we;
      w_dec.rs1    = w_use_rs1 ? w_rs1 : 5'd0;
      w_dec.rs2    = w_use_rs2 ? w_rs2 : 5'd0;
      w_dec.rd     = w_rd_we   ? w_rd  : 5'd0;
    end else begin
      w_dec.rs1_en = 1'b0;
      w_dec.rs2_en = 1'b0;
      w_dec.rd_we  = 1'b0;
    end
  end

  kamikaze_immgen #(.XLEN(XLEN)) u_immgen (
    .instr_i (instr_i[31:7]),
    .fmt_i   (w_fmt),
    .imm_o   (w_imm)
  );

  assign w_load = valid_i && ready_o;

`ifdef KAMIKAZE_DEC_SKID_EN
  logic            r_skid_valid;
  dec_t            r_skid;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_imm;

  assign ready_o = !r_skid_valid;

  // Output stage plus skid entry; the skid drains into the output when it frees up.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid      <= 1'b0;
      r_out        <= '0;
      r_pc         <= '0;
      r_imm        <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_pc    <= '0;
      r_skid_imm   <= '0;
    end else if (flush_i) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_valid || ready_i) begin
      if (r_skid_valid) begin
        r_valid      <= 1'b1;
        r_out        <= r_skid;
        r_pc         <= r_skid_pc;
        r_imm        <= r_skid_imm;
        r_skid_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_out   <= w_dec;
        r_pc    <= pc_i;
        r_imm   <= w_imm;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (w_load) begin
      r_skid_valid <= 1'b1;
      r_skid       <= w_dec;
      r_skid_pc    <= pc_i;
      r_skid_imm   <= w_imm;
    end
  end
`else
  assign ready_o = !r_valid || ready_i;

  // Single output stage: flush beats load, load beats drain, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_pc    <= '0;
      r_imm   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_out   <= w_dec;
      r_pc    <= pc_i;
      r_imm   <= w_imm;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end
`endif

  assign valid_o    = r_valid;
  assign pc_o       = r_pc;
  assign imm_o      = r_imm;
  assign opc_o      = r_out.opc;
  assign funct3_o   = r_out.funct3;
  assign funct7b5_o = r_out.funct7b5;
  assign rs1_o      = r_out.rs1[RW-1:0];
  assign rs2_o      = r_out.rs2[RW-1:0];
  assign rd_o       = r_out.rd[RW-1:0];
  assign rs1_en_o   = r_out.rs1_en;
  assign rs2_en_o   = r_out.rs2_en;
  assign rd_we_o    = r_out.rd_we;
  assign illegal_o  = r_out.illegal;

endmodule

// File: tb/tb_kamikaze_idecode.sv
// tb_kamikaze_idecode: directed self-checking bench for kamikaze_idecode (RV32I and RV32E instances).
module tb_kamikaze_idecode;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        flush_i;
  logic        ready_i;

  logic        ready_o, valid_o, funct7b5_o, rs1_en_o, rs2_en_o, rd_we_o, illegal_o;
  logic [31:0] pc_o, imm_o;
  logic [4:0]  opc_o, rs1_o, rs2_o, rd_o;
  logic [2:0]  funct3_o;

  logic        e_ready_o, e_valid_o, e_funct7b5_o, e_rs1_en_o, e_rs2_en_o, e_rd_we_o, e_illegal_o;
  logic [31:0] e_pc_o, e_imm_o;
  logic [4:0]  e_opc_o;
  logic [3:0]  e_rs1_o, e_rs2_o, e_rd_o;
  logic [2:0]  e_funct3_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  kamikaze_idecode dut (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
    .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .imm_o(imm_o),
    .opc_o(opc_o), .funct3_o(funct3_o), .funct7b5_o(funct7b5_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .rs1_en_o(rs1_en_o),
    .rs2_en_o(rs2_en_o), .rd_we_o(rd_we_o), .illegal_o(illegal_o)
  );

  kamikaze_idecode #(.NREGS(16)) dut_e (
    .clk_i(clk), .rst_i(rst_i), .instr_i(instr_i), .pc_i(pc_i),
    .valid_i(valid_i), .ready_o(e_ready_o), .flush_i(flush_i),
    .valid_o(e_valid_o), .ready_i(ready_i), .pc_o(e_pc_o), .imm_o(e_imm_o),
    .opc_o(e_opc_o), .funct3_o(e_funct3_o), .funct7b5_o(e_funct7b5_o),
    .rs1_o(e_rs1_o), .rs2_o(e_rs2_o), .rd_o(e_rd_o), .rs1_en_o(e_rs1_en_o),
    .rs2_en_o(e_rs2_en_o), .rd_we_o(e_rd_we_o), .illegal_o(e_illegal_o)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    instr_i = ins; pc_i = pc; valid_i = 1'b1; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
    instr_i = 32'hFFF00093; pc_i = 32'h0000_0010;
    step(); step();
    rst_i = 1'b0; valid_i = 1'b0; #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset valid_o got %0b want 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset ready_o got %0b want 1", ready_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset pc_o got %h want 0", pc_o); end
    checks++; if (imm_o !== 32'h0) begin errors++; $display("FAIL reset imm_o got %h want 0", imm_o); end
    checks++; if ({rd_we_o, rs1_en_o, rs2_en_o, illegal_o} !== 4'b0000) begin errors++;
      $display("FAIL reset flags got %b want 0000", {rd_we_o, rs1_en_o, rs2_en_o, illegal_o}); end
  endtask

  task automatic test_alu();
    send(32'hFFF00093, 32'h0000_0100);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL alu valid_o got %0b want 1", valid_o); end
    checks++; if (opc_o !== 5'b00100) begin errors++; $display("FAIL alu opc_o got %b want 00100", opc_o); end
    checks++; if (rd_o !== 5'd1) begin errors++; $display("FAIL alu rd_o got %0d want 1", rd_o); end
    checks++; if (rd_we_o !== 1'b1) begin errors++; $display("FAIL alu rd_we_o got %0b want 1", rd_we_o); end
    checks++; if (rs1_en_o !== 1'b1) begin errors++; $display("FAIL alu rs1_en_o got %0b want 1", rs1_en_o); end
    checks++; if (rs2_en_o !== 1'b0) begin errors++; $display("FAIL alu rs2_en_o got %0b want 0", rs2_en_o); end
    checks++; if (imm_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL alu imm_o got %h want ffffffff", imm_o); end
    checks++; if (pc_o !== 32'h0000_0100) begin errors++; $display("FAIL alu pc_o got %h want 00000100", pc_o); end
    checks++; if ({funct3_o, funct7b5_o} !== 4'b0001) begin errors++; $display("FAIL alu funct got %b want 0001", {funct3_o, funct7b5_o}); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL alu drain valid_o got %0b want 0", valid_o); end
  endtask

  task automatic test_branch();
    send(32'hFE208EE3, 32'h0000_0120);
    checks++; if (rs1_o !== 5'd1) begin errors++; $display("FAIL branch rs1_o got %0d want 1", rs1_o); end
    checks++; if (rs2_o !== 5'd2) begin errors++; $display("FAIL branch rs2_o got %0d want 2", rs2_o); end
    checks++; if (rd_we_o !== 1'b0) begin errors++; $display("FAIL branch rd_we_o got %0b want 0", rd_we_o); end
    checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL branch rd_o got %0d want 0", rd_o); end
    checks++; if (imm_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL branch imm_o got %h want fffffffc", imm_o); end
    checks++; if (opc_o !== 5'b11000) begin errors++; $display("FAIL branch opc_o got %b want 11000", opc_o); end
  endtask

  task automatic test_formats();
    logic [31:0] ins [10] = '{32'h123452B7, 32'hFFFFF317, 32'h008000EF, 32'hFE20AC23, 32'h002081B3,
                              32'h00000013, 32'h01012203, 32'h00008067, 32'h00000073, 32'h0000000F};
    logic [31:0] imm [10] = '{32'h12345000, 32'hFFFFF000, 32'h00000008, 32'hFFFFFFF8, 32'h0,
                              32'h0, 32'h00000010, 32'h0, 32'h0, 32'h0};
    logic [4:0]  rd  [10] = '{5'd5, 5'd6, 5'd1, 5'd0, 5'd3, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0};
    // flags are {rd_we, rs1_en, rs2_en, illegal}
    logic [3:0]  flg [10] = '{4'b1000, 4'b1000, 4'b1000, 4'b0110, 4'b1110,
                              4'b0100, 4'b1100, 4'b0100, 4'b0000, 4'b0001};
    for (int i = 0; i < 10; i++) begin
      send(ins[i], 32'h0000_1000 + 32'(i * 4));
      checks++; if (imm_o !== imm[i]) begin errors++; $display("FAIL fmt[%0d] imm_o got %h want %h", i, imm_o, imm[i]); end
      checks++; if (rd_o !== rd[i]) begin errors++; $display("FAIL fmt[%0d] rd_o got %0d want %0d", i, rd_o, rd[i]); end
      checks++; if ({rd_we_o, rs1_en_o, rs2_en_o, illegal_o} !== flg[i]) begin errors++;
        $display("FAIL fmt[%0d] flags got %b want %b", i, {rd_we_o, rs1_en_o, rs2_en_o, illegal_o}, flg[i]); end
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b1; valid_i = 1'b0; step();
    instr_i = 32'hFFF00093; pc_i = 32'h0000_0200; valid_i = 1'b1; ready_i = 1'b0;
    step();
    instr_i = 32'h002081B3; pc_i = 32'h0000_0204; #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h200) begin errors++; $display("FAIL bp first valid/pc got %0b/%h want 1/200", valid_o, pc_o); end
`ifdef KAMIKAZE_DEC_SKID_EN
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp skid ready_o got %0b want 1", ready_o); end
`else
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp base ready_o got %0b want 0", ready_o); end
`endif
    step();
`ifdef KAMIKAZE_DEC_SKID_EN
    valid_i = 1'b0;
`endif
    for (int c = 0; c < 2; c++) begin
      checks++; if (pc_o !== 32'h200 || imm_o !== 32'hFFFF_FFFF || valid_o !== 1'b1) begin errors++;
        $display("FAIL bp hold[%0d] pc/imm/valid got %h/%h/%0b want 200/ffffffff/1", c, pc_o, imm_o, valid_o); end
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp hold[%0d] ready_o got %0b want 0", c, ready_o); end
      if (c == 0) step();
    end
    step();
    ready_i = 1'b1; #1;
`ifdef KAMIKAZE_DEC_SKID_EN
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp skid release ready_o got %0b want 0", ready_o); end
`else
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp base release ready_o got %0b want 1", ready_o); end
`endif
    step();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h204) begin errors++; $display("FAIL bp second valid/pc got %0b/%h want 1/204", valid_o, pc_o); end
    checks++; if (rd_o !== 5'd3 || rs2_o !== 5'd2) begin errors++; $display("FAIL bp second rd/rs2 got %0d/%0d want 3/2", rd_o, rs2_o); end
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp drain valid_o got %0b want 0", valid_o); end
  endtask

  task automatic test_flush();
    ready_i = 1'b1; valid_i = 1'b0; step();
    instr_i = 32'hFFF00093; pc_i = 32'h0000_0300; valid_i = 1'b1; ready_i = 1'b0;
    step();
    instr_i = 32'h002081B3; pc_i = 32'h0000_0304;
    step();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL flush pre valid_o got %0b want 1", valid_o); end
    instr_i = 32'h123452B7; pc_i = 32'h0000_0308; valid_i = 1'b1; ready_i = 1'b1; flush_i = 1'b1;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush valid_o got %0b want 0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush ready_o got %0b want 1", ready_o); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush ghost[%0d] valid_o got %0b pc %h want 0", c, valid_o, pc_o); end
    end
  endtask

  task automatic test_illegal();
    send(32'h00000001, 32'h0000_0400);
    checks++; if (valid_o !== 1'b1 || illegal_o !== 1'b1) begin errors++; $display("FAIL ill16 valid/illegal got %0b/%0b want 1/1", valid_o, illegal_o); end
    checks++; if (pc_o !== 32'h400) begin errors++; $display("FAIL ill16 pc_o got %h want 400", pc_o); end
    checks++; if ({rd_we_o, rs1_en_o, rs2_en_o} !== 3'b000) begin errors++; $display("FAIL ill16 enables got %b want 000", {rd_we_o, rs1_en_o, rs2_en_o}); end
    send(32'h010000B3, 32'h0000_0404);
    checks++; if (e_illegal_o !== 1'b1 || e_rd_we_o !== 1'b0) begin errors++; $display("FAIL rv32e illegal/rd_we got %0b/%0b want 1/0", e_illegal_o, e_rd_we_o); end
    checks++; if (e_valid_o !== 1'b1 || e_rs2_en_o !== 1'b0 || e_pc_o !== 32'h404) begin errors++;
      $display("FAIL rv32e valid/rs2_en/pc got %0b/%0b/%h want 1/0/404", e_valid_o, e_rs2_en_o, e_pc_o); end
    checks++; if (illegal_o !== 1'b0 || rd_we_o !== 1'b1 || rs2_o !== 5'd16) begin errors++;
      $display("FAIL rv32i x16 illegal/rd_we/rs2 got %0b/%0b/%0d want 0/1/16", illegal_o, rd_we_o, rs2_o); end
  endtask

  task automatic test_reset_stall();
    ready_i = 1'b1; valid_i = 1'b0; step();
    instr_i = 32'hFFF00093; pc_i = 32'h0000_0600; valid_i = 1'b1; ready_i = 1'b0;
    step();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL rst stall pre valid_o got %0b want 1", valid_o); end
    instr_i = 32'h002081B3; rst_i = 1'b1;
    step();
    rst_i = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL rst stall valid/ready got %0b/%0b want 0/1", valid_o, ready_o); end
    checks++; if (pc_o !== 32'h0 || imm_o !== 32'h0 || opc_o !== 5'd0 || funct3_o !== 3'd0) begin errors++;
      $display("FAIL rst stall pc/imm/opc/f3 got %h/%h/%0d/%0d want 0", pc_o, imm_o, opc_o, funct3_o); end
    checks++; if ({rd_o, rs1_o, rs2_o, rd_we_o, rs1_en_o, rs2_en_o, illegal_o, funct7b5_o} !== 20'd0) begin errors++;
      $display("FAIL rst stall fields got %h want 0", {rd_o, rs1_o, rs2_o, rd_we_o, rs1_en_o, rs2_en_o, illegal_o, funct7b5_o}); end
    pc_i = 32'h0000_0604; valid_i = 1'b1; ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h604) begin errors++; $display("FAIL rst first xfer valid/pc got %0b/%h want 1/604", valid_o, pc_o); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_formats();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
